bsg_cache_to_dram_ctrl_arb: RTL



---
 rtl/bsg_cache_to_dram_ctrl_arb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bsg_cache_to_dram_ctrl_arb.sv
// Round-robin DMA arbiter: N caches share one DRAM controller port.
// Tags are queued per direction so data beats follow grant order.
module bsg_cache_to_dram_ctrl_arb_tag_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];
  logic [ptr_w-1:0]   wptr_q, wptr_d;
  logic [ptr_w-1:0]   rptr_q, rptr_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;

  function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign data_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == cnt_w'(els_p));

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d = inc(wptr_q);
    end
    if (pop_i) rptr_d = inc(rptr_q);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module bsg_cache_to_dram_ctrl_arb #(
  parameter int num_dma_p        = 4,
  parameter int dma_addr_width_p = 8,
  parameter int dma_mask_width_p = 4,
  parameter int dma_data_width_p = 8,
  parameter int dma_burst_len_p  = 2,
  parameter int tag_fifo_els_p   = 4,
  localparam int lg_lp = (num_dma_p > 1) ? $clog2(num_dma_p) : 1,
  localparam int pkt_w = 1 + dma_mask_width_p + dma_addr_width_p,
  localparam int dw    = dma_data_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [num_dma_p*pkt_w-1:0] dma_pkt_i,
  input  logic [num_dma_p-1:0]     dma_pkt_v_i,
  output logic [num_dma_p-1:0]     dma_pkt_yumi_o,
  output logic [num_dma_p*dw-1:0]  dma_data_o,
  output logic [num_dma_p-1:0]     dma_data_v_o,
  input  logic [num_dma_p-1:0]     dma_data_ready_i,
  input  logic [num_dma_p*dw-1:0]  dma_data_i,
  input  logic [num_dma_p-1:0]     dma_data_v_i,
  output logic [num_dma_p-1:0]     dma_data_yumi_o,
  output logic [pkt_w-1:0]         ctrl_pkt_o,
  output logic                     ctrl_pkt_v_o,
  input  logic                     ctrl_pkt_yumi_i,
  output logic [lg_lp-1:0]         ctrl_pkt_id_o,
  input  logic [dw-1:0]            ctrl_rdata_i,
  input  logic                     ctrl_rdata_v_i,
  output logic                     ctrl_rdata_ready_o,
  output logic [dw-1:0]            ctrl_wdata_o,
  output logic                     ctrl_wdata_v_o,
  input  logic                     ctrl_wdata_yumi_i
);
  localparam int cnt_w = (dma_burst_len_p > 1) ? $clog2(dma_burst_len_p) : 1;

  logic [lg_lp-1:0] rr_q, rr_d;
  logic [cnt_w-1:0] rcnt_q, rcnt_d;
  logic [cnt_w-1:0] wcnt_q, wcnt_d;
  logic [lg_lp-1:0] win;
  logic             any_v;
  logic [pkt_w-1:0] pkt_sel;
  logic             pkt_v, grant;
  logic [lg_lp-1:0] rhead, whead;
  logic             rempty, rfull, wempty, wfull;
  logic             rd_beat, wr_beat, rpop, wpop;
  logic             push_r, push_w;

  always_comb begin
    win   = '0;
    any_v = 1'b0;
    for (int k = 0; k < num_dma_p; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= num_dma_p) idx = idx - num_dma_p;
      if (!any_v && dma_pkt_v_i[idx]) begin
        any_v = 1'b1;
        win   = lg_lp'(idx);
      end
    end
  end

  assign pkt_sel = dma_pkt_i[win*pkt_w +: pkt_w];
  assign pkt_v   = any_v & ~rfull & ~wfull;
  assign grant   = reset_n_i & pkt_v & ctrl_pkt_yumi_i;
  assign push_w  = grant & pkt_sel[pkt_w-1];
  assign push_r  = grant & ~pkt_sel[pkt_w-1];

  assign rd_beat = ctrl_rdata_v_i & dma_data_ready_i[rhead] & ~rempty;
  assign wr_beat = dma_data_v_i[whead] & ~wempty & ctrl_wdata_yumi_i;
  assign rpop    = rd_beat & (rcnt_q == cnt_w'(dma_burst_len_p - 1));
  assign wpop    = wr_beat & (wcnt_q == cnt_w'(dma_burst_len_p - 1));

  bsg_cache_to_dram_ctrl_arb_tag_fifo #(
    .els_p(tag_fifo_els_p), .width_p(lg_lp)
  ) rfifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .push_i(push_r), .data_i(win), .pop_i(rpop),
    .data_o(rhead), .empty_o(rempty), .full_o(rfull)
  );

  bsg_cache_to_dram_ctrl_arb_tag_fifo #(
    .els_p(tag_fifo_els_p), .width_p(lg_lp)
  ) wfifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .push_i(push_w), .data_i(win), .pop_i(wpop),
    .data_o(whead), .empty_o(wempty), .full_o(wfull)
  );

  always_comb begin
    rr_d   = rr_q;
    rcnt_d = rcnt_q;
    wcnt_d = wcnt_q;
    if (grant)
      rr_d = (win == lg_lp'(num_dma_p - 1)) ? '0 : win + 1'b1;
    if (rd_beat) rcnt_d = rpop ? '0 : rcnt_q + 1'b1;
    if (wr_beat) wcnt_d = wpop ? '0 : wcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q   <= '0;
      rcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      rr_q   <= rr_d;
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Handshakes are squashed while reset is held low.
  always_comb begin
    dma_pkt_yumi_o     = '0;
    dma_data_v_o       = '0;
    dma_data_yumi_o    = '0;
    ctrl_pkt_v_o       = 1'b0;
    ctrl_rdata_ready_o = 1'b0;
    ctrl_wdata_v_o     = 1'b0;
    dma_data_o         = {num_dma_p{ctrl_rdata_i}};
    ctrl_pkt_o         = pkt_sel;
    ctrl_pkt_id_o      = win;
    ctrl_wdata_o       = dma_data_i[whead*dw +: dw];
    if (reset_n_i) begin
      ctrl_pkt_v_o = pkt_v;
      if (grant) dma_pkt_yumi_o[win] = 1'b1;
      dma_data_v_o[rhead] = ctrl_rdata_v_i & ~rempty;
      ctrl_rdata_ready_o  = dma_data_ready_i[rhead] & ~rempty;
      ctrl_wdata_v_o      = dma_data_v_i[whead] & ~wempty;
      dma_data_yumi_o[whead] = wr_beat;
    end
  end
endmodule
